// File: rtl/cpc_mem_arbiter.sv
// rtl/cpc_mem_arbiter.sv - three-way arbiter (video, CPU, loader) onto one memory command port
// Optional CPC_ARB_DL_PRIORITY_EN: loader-first priority with CPU blocked while ld_active=1.
module cpc_mem_arbiter #(
    parameter int ADDR_W           = 23,
    parameter int DATA_W           = 8,
    parameter int CPU_STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              ld_active,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_din,
    output logic              ld_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_LD} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_LIMIT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, winner;
    logic [3:0]        starve_q, starve_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] vid_dout_q, cpu_dout_q;
    logic              vid_ack_q, cpu_ack_q, ld_ack_q;
    logic              ack_cycle, dl_mode, done;

`ifdef CPC_ARB_DL_PRIORITY_EN
    assign dl_mode = ld_active;
`else
    logic unused_ld_active;
    assign unused_ld_active = ld_active;
    assign dl_mode          = 1'b0;
`endif

    assign ack_cycle = vid_ack_q | cpu_ack_q | ld_ack_q;
    assign done      = (state_q == S_WAIT) && mem_ready;

    always_comb begin
        winner = OWN_NONE;
        if (dl_mode) begin
            if (ld_req)       winner = OWN_LD;
            else if (vid_req) winner = OWN_VID;
        end else if (cpu_req && (starve_q == STARVE_LIM)) begin
            winner = OWN_CPU;
        end else if (vid_req) begin
            winner = OWN_VID;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (ld_req) begin
            winner = OWN_LD;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            S_IDLE: begin
                if (!cpu_req || dl_mode) starve_d = '0;
                // The ack cycle grants nothing: the served requester is still
                // withdrawing, so a held video stream cannot slip past a pending CPU.
                if (!ack_cycle && (winner != OWN_NONE)) begin
                    state_d = S_ISSUE;
                    owner_d = winner;
                    case (winner)
                        OWN_VID: begin
                            mem_we_d   = 1'b0;
                            mem_addr_d = vid_addr;
                            mem_din_d  = '0;
                            if (cpu_req && !dl_mode) starve_d = starve_q + 4'd1;
                        end
                        OWN_CPU: begin
                            mem_we_d   = cpu_we;
                            mem_addr_d = cpu_addr;
                            mem_din_d  = cpu_din;
                            starve_d   = '0;
                        end
                        OWN_LD: begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = ld_addr;
                            mem_din_d  = ld_din;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            vid_dout_q <= '0;
            cpu_dout_q <= '0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            vid_ack_q  <= done && (owner_q == OWN_VID);
            cpu_ack_q  <= done && (owner_q == OWN_CPU);
            ld_ack_q   <= done && (owner_q == OWN_LD);
            if (done && (owner_q == OWN_VID))              vid_dout_q <= mem_dout;
            if (done && (owner_q == OWN_CPU) && !mem_we_q) cpu_dout_q <= mem_dout;
        end
    end

    assign mem_req  = (state_q == S_ISSUE);
    assign busy     = (state_q != S_IDLE);
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign vid_dout = vid_dout_q;
    assign cpu_dout = cpu_dout_q;
    assign vid_ack  = vid_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign ld_ack   = ld_ack_q;

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// tb/tb_cpc_mem_arbiter.sv - scoreboard bench for cpc_mem_arbiter with directed vectors
module tb_cpc_mem_arbiter;

    localparam int AW = 23;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_dout;
    logic          vid_ack;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ack;
    logic          ld_active = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_din = '0;
    logic          ld_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_ready = 1'b0;
    logic          busy;

    always #5 CLK = ~CLK;

    cpc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_STARVE_LIMIT(4)) dut (
        .CLK(CLK), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ld_active(ld_active), .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] rdata;
        int            dly;
        bit            hold;
    } cmd_t;

    typedef struct {
        int            who;
        logic [DW-1:0] vd;
        logic [DW-1:0] cd;
    } ack_t;

    cmd_t          cmd_q[$];
    ack_t          ack_q[$];
    logic [DW-1:0] m_vd = '0;
    logic [DW-1:0] m_cd = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_cyc = -10;
    int last_cmd_cyc = 0;
    int last_ack_cyc = 0;
    int last_req_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no response within bound", name);
    endtask

    function automatic void push_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic [DW-1:0] r, input int dly, input bit hold);
        cmd_t c;
        c.we = we; c.addr = a; c.din = d; c.rdata = r; c.dly = dly; c.hold = hold;
        cmd_q.push_back(c);
    endfunction

    function automatic void push_ack(input int who);
        ack_t k;
        k.who = who; k.vd = m_vd; k.cd = m_cd;
        ack_q.push_back(k);
    endfunction

    function automatic void exp_vid(input logic [AW-1:0] a, input logic [DW-1:0] r, input int dly);
        push_cmd(1'b0, a, '0, r, dly, 1'b1);
        m_vd = r;
        push_ack(1);
    endfunction

    function automatic void exp_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [DW-1:0] r, input int dly);
        push_cmd(we, a, d, r, dly, 1'b1);
        if (!we) m_cd = r;
        push_ack(2);
    endfunction

    function automatic void exp_ld(input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
        push_cmd(1'b1, a, d, 8'hEE, dly, 1'b1);
        push_ack(3);
    endfunction

    // Memory-side monitor and responder
    initial begin
        cmd_t e;
        forever begin
            @(negedge CLK);
            if (mem_req) begin
                last_cmd_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected: got addr 0x%0h we %0b, expected no command", mem_addr, mem_we);
                    e.we = mem_we; e.addr = mem_addr; e.din = mem_din; e.rdata = '0; e.dly = 2; e.hold = 1'b0;
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_we", 32'(mem_we), 32'(e.we));
                    check("cmd_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("cmd_din", 32'(mem_din), 32'(e.din));
                end
                @(negedge CLK);
                check("mem_req_one_cycle", 32'(mem_req), 32'd0);
                for (int k = 0; k < e.dly - 1; k++) @(posedge CLK);
                if (e.hold) begin
                    check("wait_addr_hold", 32'(mem_addr), 32'(e.addr));
                    check("wait_we_hold", 32'(mem_we), 32'(e.we));
                end
                #1;
                mem_dout  = e.rdata;
                mem_ready = 1'b1;
                ready_cyc = cyc;
                @(posedge CLK);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    // Completion monitor
    initial begin
        ack_t k;
        int   n;
        forever begin
            @(negedge CLK);
            n = int'(vid_ack) + int'(cpu_ack) + int'(ld_ack);
            if (n != 0) begin
                last_ack_cyc = cyc;
                check("ack_onehot", 32'(n), 32'd1);
                check("ack_after_ready", 32'(cyc), 32'(ready_cyc + 1));
                if (ack_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ack_unexpected: got vid/cpu/ld %0b%0b%0b, expected none", vid_ack, cpu_ack, ld_ack);
                end else begin
                    k = ack_q.pop_front();
                    check("ack_who", vid_ack ? 32'd1 : (cpu_ack ? 32'd2 : 32'd3), 32'(k.who));
                    if (k.who != 2) check("vid_dout", 32'(vid_dout), 32'(k.vd));
                    if (k.who != 1) check("cpu_dout", 32'(cpu_dout), 32'(k.cd));
                end
            end
        end
    end

    task automatic wait_ack(input int who, output bit got);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            case (who)
                1:       got = vid_ack;
                2:       got = cpu_ack;
                default: got = ld_ack;
            endcase
        end
    endtask

    task automatic cpu_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        @(posedge CLK);
        #1;
        cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
        last_req_cyc = cyc;
        wait_ack(2, got);
        if (!got) fail_msg("cpu_ack_timeout");
        cpu_req = 1'b0;
    endtask

    task automatic ld_xact(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        @(posedge CLK);
        #1;
        ld_addr = a; ld_din = d; ld_req = 1'b1;
        wait_ack(3, got);
        if (!got) fail_msg("ld_ack_timeout");
        ld_req = 1'b0;
    endtask

    task automatic vid_stream(input int n, input logic [AW-1:0] base);
        bit got;
        @(posedge CLK);
        #1;
        vid_addr = base; vid_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_ack(1, got);
            if (!got) begin
                fail_msg("vid_ack_timeout");
                break;
            end
            vid_addr = base + AW'(i + 1);
        end
        vid_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_vid_dout", 32'(vid_dout), 32'd0);
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_ld_ack", 32'(ld_ack), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        // Single CPU read with exact latency
        exp_cpu(1'b0, 23'h004000, 8'h00, 8'hA5, 2);
        cpu_xact(1'b0, 23'h004000, 8'h00);
        @(posedge CLK);
        check("t1_cmd_latency", 32'(last_cmd_cyc - last_req_cyc), 32'd1);
        check("t1_ack_latency", 32'(last_ack_cyc - last_req_cyc), 32'd4);
        repeat (2) @(posedge CLK);

        // All three at once: vid, cpu, ld
        exp_vid(23'h000100, 8'h11, 2);
        exp_cpu(1'b0, 23'h004001, 8'h00, 8'h22, 3);
        exp_ld(23'h400001, 8'h33, 2);
        fork
            vid_stream(1, 23'h000100);
            cpu_xact(1'b0, 23'h004001, 8'h00);
            ld_xact(23'h400001, 8'h33);
        join
        repeat (2) @(posedge CLK);

        // Held video with pending CPU: four video grants, then CPU, twice
        for (int i = 0; i < 4; i++) exp_vid(23'h200000 + 23'(i), 8'h40 + 8'(i), 2);
        exp_cpu(1'b0, 23'h008000, 8'h00, 8'h80, 2);
        for (int i = 4; i < 8; i++) exp_vid(23'h200000 + 23'(i), 8'h40 + 8'(i), 2);
        exp_cpu(1'b0, 23'h008001, 8'h00, 8'h81, 2);
        exp_vid(23'h200008, 8'h48, 2);
        fork
            vid_stream(9, 23'h200000);
            begin
                cpu_xact(1'b0, 23'h008000, 8'h00);
                cpu_xact(1'b0, 23'h008001, 8'h00);
            end
        join
        repeat (2) @(posedge CLK);

        // Loader write leaves read data untouched
        exp_ld(23'h400000, 8'h3C, 3);
        ld_xact(23'h400000, 8'h3C);
        repeat (2) @(posedge CLK);

        // Reset during WAIT, late mem_ready ignored
        push_cmd(1'b0, 23'h001234, 8'h00, 8'h77, 4, 1'b0);
        @(posedge CLK);
        #1;
        cpu_we = 1'b0; cpu_addr = 23'h001234; cpu_req = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        m_vd = '0;
        m_cd = '0;
        @(negedge CLK);
        check("rstw_mem_req", 32'(mem_req), 32'd0);
        check("rstw_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rstw_vid_dout", 32'(vid_dout), 32'd0);
        check("rstw_mem_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rstw_busy", 32'(busy), 32'd0);
            @(negedge CLK);
        end
        exp_cpu(1'b1, 23'h000010, 8'h5A, 8'h00, 2);
        cpu_xact(1'b1, 23'h000010, 8'h5A);
        exp_cpu(1'b0, 23'h000010, 8'h00, 8'h5A, 2);
        cpu_xact(1'b0, 23'h000010, 8'h00);
        repeat (2) @(posedge CLK);

        // Download priority (ld_active ignored in the default build)
        ld_active = 1'b1;
`ifdef CPC_ARB_DL_PRIORITY_EN
        exp_ld(23'h400010, 8'hC1, 2);
        exp_ld(23'h400011, 8'hC2, 2);
        exp_cpu(1'b0, 23'h00C000, 8'h00, 8'h9C, 2);
`else
        exp_cpu(1'b0, 23'h00C000, 8'h00, 8'h9C, 2);
        exp_ld(23'h400010, 8'hC1, 2);
        exp_ld(23'h400011, 8'hC2, 2);
`endif
        fork
            cpu_xact(1'b0, 23'h00C000, 8'h00);
            begin
                ld_xact(23'h400010, 8'hC1);
                ld_xact(23'h400011, 8'hC2);
                repeat (5) @(posedge CLK);
                #1;
                ld_active = 1'b0;
            end
        join

        for (int i = 0; i < 50 && (cmd_q.size() != 0 || ack_q.size() != 0); i++) @(posedge CLK);
        check("cmd_q_left", 32'(cmd_q.size()), 32'd0);
        check("ack_q_left", 32'(ack_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
